seq_divider: RTL and testbench

- Sequential restoring divider; the inverse of the team's combinational array multiplier.
- Takes a DW-bit dividend (product width) and a VW-bit divisor, and produces quotient and remainder one bit per clock.
- Used wherever a multiplier result must be decomposed back into its factors, or where a generic small integer divide is needed.
- Single start/busy/done handshake; results stay registered until the next operation completes.

---
 rtl/seq_divider.sv | 143 ++++++++++++++
 tb/tb_seq_divider.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Sequential restoring divider: DW-bit dividend / VW-bit divisor, one quotient bit per clock.
// Define SEQ_DIVIDER_CHECK_EN to add a multiply-back self-check that drives check_err.
module seq_divider #(
    parameter int DW = 7,
    parameter int VW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          dbz,
    output logic          check_err
);

    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    // Handshake: start is honoured only in IDLE; busy is high for DW cycles,
    // then done pulses for one cycle while the result registers hold the new values.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [DW-1:0] q_reg;
    logic [VW-1:0] d_reg;
    logic [VW:0]   p_reg;
    logic [CW-1:0] cnt;

    logic [VW:0]   trial;
    logic [VW:0]   diff;
    logic          fits;
    logic [VW:0]   p_step;
    logic [DW-1:0] q_step;
    logic          last_iter;
    logic          chk_fail;

    // The partial remainder never exceeds the divisor after an iteration, so its MSB is never read back.
    logic          unused_p_msb;
    assign unused_p_msb = p_reg[VW];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (cnt == '0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy      = (state == RUN);
    assign done      = (state == DONE);
    assign last_iter = (state == RUN) && (cnt == '0);

    // One restoring step: bring down the next dividend bit, subtract if it fits.
    always_comb begin
        trial  = {p_reg[VW-1:0], q_reg[DW-1]};
        fits   = (trial >= {1'b0, d_reg});
        diff   = trial - {1'b0, d_reg};
        p_step = fits ? diff : trial;
        q_step = (q_reg << 1) | DW'(fits);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_reg     <= '0;
            d_reg     <= '0;
            p_reg     <= '0;
            cnt       <= '0;
            quotient  <= '0;
            remainder <= '0;
            dbz       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        q_reg <= dividend;
                        d_reg <= divisor;
                        p_reg <= '0;
                        cnt   <= CW'(DW - 1);
                    end
                end
                RUN: begin
                    q_reg <= q_step;
                    p_reg <= p_step;
                    cnt   <= cnt - 1'b1;
                    if (last_iter) begin
                        quotient  <= q_step;
                        remainder <= p_step[VW-1:0];
                        dbz       <= (d_reg == '0);
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef SEQ_DIVIDER_CHECK_EN
    logic [DW-1:0] dvd_reg;
    logic [DW-1:0] prod;

    // Rebuild quotient*divisor from shifted partial products, then add the remainder.
    always_comb begin
        prod = '0;
        for (int i = 0; i < VW; i++) begin
            if (d_reg[i]) prod = prod + (q_step << i);
        end
        prod     = prod + DW'(p_step[VW-1:0]);
        chk_fail = (prod != dvd_reg) && (d_reg != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dvd_reg   <= '0;
            check_err <= 1'b0;
        end else begin
            if (state == IDLE && start) dvd_reg <= dividend;
            if (last_iter) check_err <= chk_fail;
        end
    end
`else
    assign chk_fail  = 1'b0;
    assign check_err = chk_fail;
`endif

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: vector table, corner sequences, exhaustive sweep.
module tb_seq_divider;
    localparam int DW = 7;
    localparam int VW = 4;
    localparam int RW = DW + VW + 2;  // {quotient, remainder, dbz, check_err}

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          busy;
    logic          done;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          dbz;
    logic          check_err;

    always #5 clk = ~clk;

    seq_divider #(.DW(DW), .VW(VW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .dbz       (dbz),
        .check_err (check_err)
    );

    typedef struct {
        logic [DW-1:0] a;
        logic [VW-1:0] b;
        logic [DW-1:0] q;
        logic [VW-1:0] r;
        logic          z;
    } vec_t;

    logic [RW-1:0] exp_q[$];
    logic [RW-1:0] exp_e;
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [RW-1:0] model(input logic [DW-1:0] a, input logic [VW-1:0] b);
        logic [DW-1:0] q;
        logic [VW-1:0] r;
        if (b == '0) begin
            q = '1;
            r = a[VW-1:0];
        end else begin
            q = DW'(a / b);
            r = VW'(a % b);
        end
        return {q, r, (b == '0), 1'b0};
    endfunction

    // Scoreboard: every done pulse consumes one expected result.
    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done: got done with empty queue at %0t", $time);
            end else begin
                exp_e = exp_q.pop_front();
                check("quotient",  32'(quotient),  32'(exp_e[RW-1:VW+2]));
                check("remainder", 32'(remainder), 32'(exp_e[VW+1:2]));
                check("dbz",       32'(dbz),       32'(exp_e[1]));
                check("check_err", 32'(check_err), 32'(exp_e[0]));
            end
        end
    end

    task automatic launch(input logic [DW-1:0] a, input logic [VW-1:0] b,
                          input logic push, input logic [RW-1:0] e);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        if (push) exp_q.push_back(e);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(output int n, output int nb);
        n  = 0;
        nb = 0;
        while (1) begin
            @(negedge clk);
            n++;
            if (busy) nb++;
            if (done) break;
            if (n > 40) begin
                check("done_timeout", 32'(n), 32'(DW + 1));
                break;
            end
        end
    endtask

    task automatic run_op(input logic [DW-1:0] a, input logic [VW-1:0] b, input logic [RW-1:0] e);
        int n, nb;
        launch(a, b, 1'b1, e);
        wait_done(n, nb);
        check("latency", 32'(n), 32'(DW + 1));
    endtask

    vec_t vecs[12];

    initial begin
        int n, nb, ndone;

        vecs[0]  = '{a: 7'd100, b: 4'd7,  q: 7'd14,  r: 4'd2,  z: 1'b0};
        vecs[1]  = '{a: 7'd127, b: 4'd1,  q: 7'd127, r: 4'd0,  z: 1'b0};
        vecs[2]  = '{a: 7'd5,   b: 4'd9,  q: 7'd0,   r: 4'd5,  z: 1'b0};
        vecs[3]  = '{a: 7'd45,  b: 4'd0,  q: 7'd127, r: 4'd13, z: 1'b1};
        vecs[4]  = '{a: 7'd60,  b: 4'd15, q: 7'd4,   r: 4'd0,  z: 1'b0};
        vecs[5]  = '{a: 7'd0,   b: 4'd5,  q: 7'd0,   r: 4'd0,  z: 1'b0};
        vecs[6]  = '{a: 7'd127, b: 4'd15, q: 7'd8,   r: 4'd7,  z: 1'b0};
        vecs[7]  = '{a: 7'd127, b: 4'd0,  q: 7'd127, r: 4'd15, z: 1'b1};
        vecs[8]  = '{a: 7'd0,   b: 4'd0,  q: 7'd127, r: 4'd0,  z: 1'b1};
        vecs[9]  = '{a: 7'd84,  b: 4'd6,  q: 7'd14,  r: 4'd0,  z: 1'b0};
        vecs[10] = '{a: 7'd99,  b: 4'd5,  q: 7'd19,  r: 4'd4,  z: 1'b0};
        vecs[11] = '{a: 7'd15,  b: 4'd15, q: 7'd1,   r: 4'd0,  z: 1'b0};

        // Clock/reset
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_done",      32'(done),      32'd0);
        check("rst_quotient",  32'(quotient),  32'd0);
        check("rst_remainder", 32'(remainder), 32'd0);
        check("rst_dbz",       32'(dbz),       32'd0);
        check("rst_check_err", 32'(check_err), 32'd0);
        rst = 1'b0;

        // 100/7 with exact busy length and done position
        launch(7'd100, 4'd7, 1'b1, {7'd14, 4'd2, 1'b0, 1'b0});
        wait_done(n, nb);
        check("first_done_edge",  32'(n),  32'(DW + 1));
        check("first_busy_cycles", 32'(nb), 32'(DW));

        // Vector table
        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].a, vecs[i].b, {vecs[i].q, vecs[i].r, vecs[i].z, 1'b0});
        end

        // start held high, operands changed during RUN
        @(negedge clk);
        dividend = 7'd84;
        divisor  = 4'd6;
        start    = 1'b1;
        exp_q.push_back({7'd14, 4'd0, 1'b0, 1'b0});
        @(posedge clk);
        #1;
        dividend = 7'd99;
        divisor  = 4'd5;
        exp_q.push_back({7'd19, 4'd4, 1'b0, 1'b0});
        wait_done(n, nb);
        check("held_first_latency", 32'(n), 32'(DW + 1));
        @(negedge clk);
        check("held_idle_busy", 32'(busy), 32'd0);
        check("held_idle_done", 32'(done), 32'd0);
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(n, nb);
        check("held_second_latency", 32'(n), 32'(DW + 1));

        // Reset in the 3rd RUN cycle aborts without a done pulse
        launch(7'd100, 4'd7, 1'b0, '0);
        repeat (3) @(negedge clk);
        check("abort_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("abort_busy",      32'(busy),      32'd0);
        check("abort_done",      32'(done),      32'd0);
        check("abort_quotient",  32'(quotient),  32'd0);
        check("abort_remainder", 32'(remainder), 32'd0);
        check("abort_dbz",       32'(dbz),       32'd0);
        check("abort_check_err", 32'(check_err), 32'd0);
        @(negedge clk);
        rst   = 1'b0;
        ndone = 0;
        repeat (15) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("abort_no_done", 32'(ndone), 32'd0);
        run_op(7'd60, 4'd15, {7'd4, 4'd0, 1'b0, 1'b0});

        // Exhaustive sweep against the reference model
        for (int a = 0; a < (1 << DW); a++) begin
            for (int b = 0; b < (1 << VW); b++) begin
                launch(DW'(a), VW'(b), 1'b1, model(DW'(a), VW'(b)));
                wait_done(n, nb);
            end
        end

        @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
